spi_sclk_engine: RTL and testbench



---
 rtl/spi_pkg.sv | 13 +
 rtl/spi_half_period_counter.sv | 44 ++++
 rtl/spi_sclk_engine.sv | 173 +++++++++++++++++
 tb/tb_spi_sclk_engine.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and default widths for the SPI serial-clock engine.
package spi_pkg;

  localparam int unsigned DefDivW  = 8;
  localparam int unsigned DefBitsW = 5;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StTrail = 2'd2
  } spi_state_e;

endpackage

// File: rtl/spi_half_period_counter.sv
// Half-period counter: counts 0..i_div and wraps, raising o_wrap on the wrap cycle.
// A stall at terminal count holds the counter at i_div and suppresses the wrap.
module spi_half_period_counter
  import spi_pkg::*;
#(
  parameter int unsigned DIV_W = DefDivW
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_clear,
  input  logic             i_en,
  input  logic             i_stall,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_wrap
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             at_end;

  assign at_end = (cnt_q == i_div);
  assign o_wrap = i_en & at_end & ~i_stall;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clear) begin
      cnt_d = '0;
    end else if (i_en) begin
      if (at_end) begin
        cnt_d = i_stall ? cnt_q : '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_sclk_engine.sv
// SPI master SCLK engine: N SCLK cycles per start with CPOL/CPHA-aware edge strobes.
// Define SPI_SCLK_ENGINE_STALL_EN to add the i_stall edge-hold input.
module spi_sclk_engine
  import spi_pkg::*;
#(
  parameter int unsigned DIV_W  = DefDivW,
  parameter int unsigned BITS_W = DefBitsW
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_cpol,
  input  logic              i_cpha,
  input  logic [DIV_W-1:0]  i_div,
  input  logic [BITS_W-1:0] i_nbits,
  input  logic              i_start,
`ifdef SPI_SCLK_ENGINE_STALL_EN
  input  logic              i_stall,
`endif
  output logic              o_busy,
  output logic              o_done,
  output logic              o_sclk,
  output logic              o_sclk_rise,
  output logic              o_sclk_fall,
  output logic              o_sample,
  output logic              o_setup,
  output logic [BITS_W-1:0] o_bit_idx
);

  // Two extra bits so that 2N = 2^(BITS_W+1) is representable.
  localparam int unsigned EdgeW = BITS_W + 2;

  spi_state_e        state_q, state_d;
  logic              cpol_q, cpol_d;
  logic              cpha_q, cpha_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [BITS_W-1:0] nbits_q, nbits_d;
  logic [EdgeW-1:0]  edge_q, edge_d;
  logic              sclk_q, sclk_d;
  logic              rise_q, rise_d;
  logic              fall_q, fall_d;
  logic              sample_q, sample_d;
  logic              setup_q, setup_d;
  logic              done_q, done_d;
  logic [BITS_W-1:0] bit_idx_q, bit_idx_d;

  logic             wrap;
  logic             stall_run;
  logic [EdgeW-1:0] edge_num;
  logic [EdgeW-1:0] two_n;
  logic             leading;
  logic             last_edge;

`ifdef SPI_SCLK_ENGINE_STALL_EN
  assign stall_run = i_stall & (state_q == StRun);
`else
  assign stall_run = 1'b0;
`endif

  spi_half_period_counter #(
    .DIV_W (DIV_W)
  ) u_half_period_counter (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clear (state_q == StIdle),
    .i_en    (state_q != StIdle),
    .i_stall (stall_run),
    .i_div   (div_q),
    .o_wrap  (wrap)
  );

  assign edge_num  = edge_q + 1'b1;
  assign two_n     = (EdgeW'(nbits_q) + EdgeW'(1)) << 1;
  assign leading   = edge_num[0];
  assign last_edge = (edge_num == two_n);

  always_comb begin
    state_d   = state_q;
    cpol_d    = cpol_q;
    cpha_d    = cpha_q;
    div_d     = div_q;
    nbits_d   = nbits_q;
    edge_d    = edge_q;
    sclk_d    = sclk_q;
    rise_d    = 1'b0;
    fall_d    = 1'b0;
    sample_d  = 1'b0;
    setup_d   = 1'b0;
    done_d    = 1'b0;
    bit_idx_d = bit_idx_q;

    if (sample_q && (bit_idx_q != nbits_q)) begin
      bit_idx_d = bit_idx_q + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        sclk_d = i_cpol;
        if (i_start) begin
          cpol_d    = i_cpol;
          cpha_d    = i_cpha;
          div_d     = i_div;
          nbits_d   = i_nbits;
          edge_d    = '0;
          bit_idx_d = '0;
          state_d   = StRun;
        end
      end
      StRun: begin
        if (wrap) begin
          sclk_d   = ~sclk_q;
          rise_d   = ~sclk_q;
          fall_d   = sclk_q;
          edge_d   = edge_num;
          // CPHA=0 skips setup on the final edge: the first bit was preloaded at start.
          sample_d = cpha_q ? ~leading : leading;
          setup_d  = cpha_q ? leading : (~leading & ~last_edge);
          if (last_edge) begin
            state_d = StTrail;
          end
        end
      end
      StTrail: begin
        if (wrap) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= StIdle;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      div_q     <= '0;
      nbits_q   <= '0;
      edge_q    <= '0;
      sclk_q    <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      sample_q  <= 1'b0;
      setup_q   <= 1'b0;
      done_q    <= 1'b0;
      bit_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      cpol_q    <= cpol_d;
      cpha_q    <= cpha_d;
      div_q     <= div_d;
      nbits_q   <= nbits_d;
      edge_q    <= edge_d;
      sclk_q    <= sclk_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      sample_q  <= sample_d;
      setup_q   <= setup_d;
      done_q    <= done_d;
      bit_idx_q <= bit_idx_d;
    end
  end

  assign o_busy      = (state_q != StIdle);
  assign o_done      = done_q;
  assign o_sclk      = sclk_q;
  assign o_sclk_rise = rise_q;
  assign o_sclk_fall = fall_q;
  assign o_sample    = sample_q;
  assign o_setup     = setup_q;
  assign o_bit_idx   = bit_idx_q;

endmodule

// File: tb/tb_spi_sclk_engine.sv
// Bench for spi_sclk_engine: table of transfers checked edge by edge against a queued schedule.
module tb_spi_sclk_engine;

  logic       clk = 1'b0;
  logic       rst;
  logic       cpol, cpha, start;
  logic [7:0] div;
  logic [4:0] nbits;
`ifdef SPI_SCLK_ENGINE_STALL_EN
  logic       stall;
`endif
  logic       busy, done, sclk, rise, fall, sample, setup;
  logic [4:0] bit_idx;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       cpol;
    logic       cpha;
    logic [7:0] div;
    logic [4:0] nbits;
    bit         disturb;
    int         exp_edges;
    int         exp_done;
  } vec_t;

  typedef struct {
    int offset;
    bit rise;
    bit sample;
    bit setup;
  } edge_t;

  edge_t sb[$];
  vec_t  vecs[6];

  always #5 clk = ~clk;

  spi_sclk_engine #(
    .DIV_W  (8),
    .BITS_W (5)
  ) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_cpol      (cpol),
    .i_cpha      (cpha),
    .i_div       (div),
    .i_nbits     (nbits),
    .i_start     (start),
`ifdef SPI_SCLK_ENGINE_STALL_EN
    .i_stall     (stall),
`endif
    .o_busy      (busy),
    .o_done      (done),
    .o_sclk      (sclk),
    .o_sclk_rise (rise),
    .o_sclk_fall (fall),
    .o_sample    (sample),
    .o_setup     (setup),
    .o_bit_idx   (bit_idx)
  );

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Runs one transfer; stall_edge > 0 holds i_stall for 5 cycles at that edge's terminal count.
  task automatic run_xfer(input vec_t v, input int stall_edge);
    int    dd, nn, rel, edges, samples, exp_done;
    bit    seen_done;
    edge_t e;
    dd        = int'(v.div);
    nn        = int'(v.nbits) + 1;
    edges     = 0;
    samples   = 0;
    seen_done = 1'b0;
    exp_done  = v.exp_done + ((stall_edge != 0) ? 5 : 0);
    sb.delete();
    for (int k = 1; k <= 2 * nn; k++) begin
      e.offset = 1 + k * (dd + 1) + ((stall_edge != 0 && k >= stall_edge) ? 5 : 0);
      e.rise   = v.cpol ? (k % 2 == 0) : (k % 2 == 1);
      e.sample = v.cpha ? (k % 2 == 0) : (k % 2 == 1);
      e.setup  = v.cpha ? (k % 2 == 1) : (k % 2 == 0 && k != 2 * nn);
      sb.push_back(e);
    end

    @(negedge clk);
    cpol  = v.cpol;
    cpha  = v.cpha;
    div   = v.div;
    nbits = v.nbits;
    start = 1'b0;
    @(negedge clk);
    check("idle_sclk", sclk, v.cpol);
    start = 1'b1;
    @(posedge clk);
    rel = 0;
    while (!seen_done && rel < 3000) begin
      @(negedge clk);
      rel++;
      if (rel == 1) begin
        start = 1'b0;
        check("busy_after_start", busy, 1);
      end
      if (v.disturb && rel == 3) begin
        start = 1'b1;
        div   = 8'd7;
        nbits = 5'd0;
        cpol  = ~v.cpol;
        cpha  = ~v.cpha;
      end
      if (v.disturb && rel == 4) start = 1'b0;
`ifdef SPI_SCLK_ENGINE_STALL_EN
      if (stall_edge != 0 && rel == stall_edge * (dd + 1)) stall = 1'b1;
      if (stall_edge != 0 && rel == stall_edge * (dd + 1) + 5) stall = 1'b0;
`endif
      if (rise || fall) begin
        edges++;
        check("strobe_exclusive", sample & setup, 0);
        if (sb.size() == 0) begin
          check("extra_edge", edges, 2 * nn);
        end else begin
          e = sb.pop_front();
          check("edge_time", rel, e.offset);
          check("edge_rise", rise, e.rise);
          check("edge_fall", fall, !e.rise);
          check("sclk_level", sclk, e.rise);
          check("sample", sample, e.sample);
          check("setup", setup, e.setup);
          if (sample) begin
            check("bit_idx", bit_idx, samples);
            samples++;
          end
        end
      end else if (sample || setup) begin
        check("stray_strobe", sample | setup, 0);
      end
      if (done) begin
        seen_done = 1'b1;
        check("done_time", rel, exp_done);
        check("busy_at_done", busy, 0);
        check("bit_idx_end", bit_idx, nn - 1);
      end else if (rel > 1 && !busy) begin
        check("busy_early_drop", busy, 1);
      end
    end
    check("done_seen", seen_done, 1);
    check("edge_count", edges, v.exp_edges);
    check("queue_empty", sb.size(), 0);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("idle_after_done", busy, 0);
  endtask

  initial begin
    int   quiet;
    vec_t sv;
    //          cpol  cpha  D      nbits   dist edges done
    vecs[0] = '{1'b0, 1'b0, 8'd3, 5'd7,  0, 16, 69};
    vecs[1] = '{1'b1, 1'b1, 8'd0, 5'd0,  0, 2,  4};
    vecs[2] = '{1'b0, 1'b1, 8'd1, 5'd2,  0, 6,  15};
    vecs[3] = '{1'b1, 1'b0, 8'd2, 5'd4,  0, 10, 34};
    vecs[4] = '{1'b0, 1'b0, 8'd0, 5'd31, 0, 64, 66};
    vecs[5] = '{1'b1, 1'b0, 8'd1, 5'd3,  1, 8,  19};

    rst   = 1'b1;
    cpol  = 1'b1;
    cpha  = 1'b0;
    div   = 8'd0;
    nbits = 5'd0;
    start = 1'b0;
`ifdef SPI_SCLK_ENGINE_STALL_EN
    stall = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sclk", sclk, 0);
    check("rst_edges", rise | fall, 0);
    check("rst_strobes", sample | setup, 0);
    check("rst_bit_idx", bit_idx, 0);
    rst = 1'b0;
    @(negedge clk);
    check("sclk_follows_cpol", sclk, 1);

    for (int i = 0; i < 6; i++) run_xfer(vecs[i], 0);

    // Reset on edge 5 of an N=4, D=1, CPOL=1 transfer.
    @(negedge clk);
    cpol  = 1'b1;
    cpha  = 1'b0;
    div   = 8'd1;
    nbits = 5'd3;
    start = 1'b1;
    @(posedge clk);
    for (int r = 1; r <= 10; r++) begin
      @(negedge clk);
      if (r == 1) start = 1'b0;
      if (r == 10) rst = 1'b1;
    end
    @(negedge clk);
    check("midrst_busy", busy, 0);
    check("midrst_sclk", sclk, 0);
    check("midrst_done", done, 0);
    check("midrst_strobes", rise | fall | sample | setup, 0);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_sclk_cpol", sclk, 1);
    quiet = 0;
    repeat (20) begin
      @(negedge clk);
      if (done || busy || rise || fall || sample || setup) quiet++;
    end
    check("midrst_quiet", quiet, 0);

`ifdef SPI_SCLK_ENGINE_STALL_EN
    sv = '{1'b0, 1'b0, 8'd2, 5'd1, 0, 4, 16};
    run_xfer(sv, 3);
`else
    sv = vecs[1];
    run_xfer(sv, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
